// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Brief    : Data-memory access sequencer; stalls the pipeline for one
//            load/store handshake, with a bounded wait and sticky abort flag.
// Revision : 1.0
// ============================================================================
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_enable_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        timeout_o
);

  localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_timeout;
  logic        w_req;
  logic        w_wait_expired;

  assign w_req          = MemRead_i | MemWrite_i;
  // An ack arriving on the last permitted cycle takes priority over the abort.
  assign w_wait_expired = !mem_ack_i && (r_wait_cnt == C_WAIT_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    stall_o      = 1'b0;
    mem_enable_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_o = w_req;
        if (w_req) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        stall_o      = 1'b1;
        mem_enable_o = 1'b1;
        if (mem_ack_i || w_wait_expired) w_state_nxt = S_DONE;
      end
      // DONE lets the pipeline step past the retiring op, so it never re-issues.
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wait_cnt <= 8'd0;
      r_write    <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr     <= addr_i;
            r_wdata    <= wdata_i;
            r_write    <= MemWrite_i;
            r_wait_cnt <= 8'd0;
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            if (!r_write) r_rdata <= mem_rdata_i;
          end else if (w_wait_expired) begin
            r_timeout <= 1'b1;
            if (!r_write) r_rdata <= 32'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_write_o = r_write;
  assign mem_addr_o  = r_addr;
  assign mem_data_o  = r_wdata;
  assign rdata_o     = r_rdata;
  assign timeout_o   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Brief    : Directed plus randomized transaction bench for dmem_ctrl.
// Revision : 1.0
// ============================================================================
module tb_dmem_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i, mem_ack_i;
  logic [31:0] addr_i, wdata_i, mem_rdata_i;
  logic        mem_enable_o, mem_write_o, stall_o, timeout_o;
  logic [31:0] mem_addr_o, mem_data_o, rdata_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_to = 1'b0;

  dmem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .rdata_o(rdata_o), .stall_o(stall_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Idle cycles with stray acks: nothing may start or change.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      MemRead_i = 1'b0; MemWrite_i = 1'b0;
      mem_ack_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
      #1;
      chk("idle_en", {31'd0, mem_enable_o}, 32'd0);
      chk("idle_stall", {31'd0, stall_o}, 32'd0);
      chk("idle_rdata", rdata_o, exp_rdata);
      chk("idle_timeout", {31'd0, timeout_o}, {31'd0, exp_to});
    end
    mem_ack_i = 1'b0;
  endtask

  // One transaction; ack arrives d cycles after REQ entry (never if d >= TIMEOUT).
  task automatic do_op(input string tag, input bit st, input bit both,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int d, input logic [31:0] rd, input bit hold_done);
    bit to;
    int n_req;
    int stalls;
    to     = (d >= TIMEOUT);
    n_req  = to ? TIMEOUT : d + 1;
    stalls = 0;

    @(negedge clk);
    MemRead_i = !st || both; MemWrite_i = st;
    addr_i = a; wdata_i = wd; mem_ack_i = 1'b0;
    #1;
    chk({tag, " idle_en"}, {31'd0, mem_enable_o}, 32'd0);
    stalls += int'(stall_o);

    for (int k = 0; k < n_req; k++) begin
      @(negedge clk);
      addr_i = $urandom; wdata_i = $urandom;
      mem_ack_i   = (k == d);
      mem_rdata_i = (k == d) ? rd : $urandom;
      #1;
      chk({tag, " req_en"}, {31'd0, mem_enable_o}, 32'd1);
      chk({tag, " req_addr"}, mem_addr_o, a);
      chk({tag, " req_data"}, mem_data_o, wd);
      chk({tag, " req_write"}, {31'd0, mem_write_o}, {31'd0, st});
      stalls += int'(stall_o);
    end

    if (to) exp_to = 1'b1;
    if (!st) exp_rdata = to ? 32'd0 : rd;

    @(negedge clk);
    mem_ack_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
    if (!hold_done) begin MemRead_i = 1'b0; MemWrite_i = 1'b0; end
    #1;
    chk({tag, " done_stall"}, {31'd0, stall_o}, 32'd0);
    chk({tag, " done_en"}, {31'd0, mem_enable_o}, 32'd0);
    chk({tag, " done_rdata"}, rdata_o, exp_rdata);
    chk({tag, " done_timeout"}, {31'd0, timeout_o}, {31'd0, exp_to});
    chk({tag, " stall_cycles"}, 32'(stalls), 32'(n_req + 1));
    MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
    addr_i = 32'd0; wdata_i = 32'd0; mem_rdata_i = 32'd0;

    // Reset takes effect before any clock edge.
    #2 rst_i = 1'b0;
    #1;
    chk("rst_en", {31'd0, mem_enable_o}, 32'd0);
    chk("rst_write", {31'd0, mem_write_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_data", mem_data_o, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_i = 1'b1;

    do_op("load_ack3", 1'b0, 1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
    do_op("store_ack0", 1'b1, 1'b0, 32'h0000_0010, 32'h1234_5678, 0, 32'h0, 1'b0);
    do_op("load_ack_last", 1'b0, 1'b0, 32'h0000_0100, 32'h0, TIMEOUT - 1, 32'hA5A5_A5A5, 1'b0);
    do_op("load_timeout", 1'b0, 1'b0, 32'h0000_0200, 32'h0, TIMEOUT + 4, 32'h0, 1'b0);
    do_op("load_after_to", 1'b0, 1'b0, 32'h0000_0204, 32'h0, 1, 32'hCAFE_F00D, 1'b0);
    do_op("both_is_store", 1'b1, 1'b1, 32'h0000_0300, 32'h8765_4321, 2, 32'h1111_1111, 1'b0);
    idle_cycles(3);
    do_op("held_done", 1'b0, 1'b0, 32'h0000_0400, 32'h0, 0, 32'h5555_AAAA, 1'b1);
    idle_cycles(3);

    for (int i = 0; i < 40; i++) begin
      bit st;
      st = 1'($urandom_range(0, 1));
      do_op("rand", st, st && ($urandom_range(0, 1) == 1), $urandom, $urandom,
            int'($urandom_range(0, TIMEOUT + 3)), $urandom, 1'($urandom_range(0, 1)));
      if (($urandom_range(0, 3)) == 0) idle_cycles(1);
    end

    // Reset mid-REQ drops the request with no clock edge.
    @(negedge clk);
    MemRead_i = 1'b1; addr_i = 32'h0000_0080;
    @(negedge clk); @(negedge clk);
    #1;
    chk("midreq_en", {31'd0, mem_enable_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    exp_rdata = 32'd0; exp_to = 1'b0;
    chk("midreq_rst_en", {31'd0, mem_enable_o}, 32'd0);
    chk("midreq_rst_addr", mem_addr_o, 32'd0);
    chk("midreq_rst_rdata", rdata_o, 32'd0);
    chk("midreq_rst_timeout", {31'd0, timeout_o}, 32'd0);
    chk("midreq_rst_stall", {31'd0, stall_o}, 32'd1);
    MemRead_i = 1'b0;
    #1;
    chk("midreq_rst_stall_off", {31'd0, stall_o}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_i = 1'b1;
    idle_cycles(4);
    do_op("post_reset", 1'b0, 1'b0, 32'h0000_0044, 32'h0, 2, 32'h0BAD_F00D, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 16, max REQ-state cycles awaiting mem_ack_i before abort (range 2..255).
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 MemRead_i  input  1  load request from EX/MEM pipeline register.
REQ-005 MemWrite_i  input  1  store request from EX/MEM pipeline register.
REQ-006 addr_i  input  32  byte address (EX/MEM ALU result).
REQ-007 wdata_i  input  32  store data (EX/MEM RD data).
REQ-008 mem_ack_i  input  1  data-memory completion strobe, one cycle.
REQ-009 mem_rdata_i  input  32  load data, valid in the cycle mem_ack_i=1.
REQ-010 mem_enable_o  output  1  memory request valid.
REQ-011 mem_write_o  output  1  1=store, 0=load; valid when mem_enable_o=1.
REQ-012 mem_addr_o  output  32  registered request address.
REQ-013 mem_data_o  output  32  registered store data.
REQ-014 rdata_o  output  32  load result to MEM/WB.
REQ-015 stall_o  output  1  freeze PC, IF/ID, ID/EX, EX/MEM.
REQ-016 timeout_o  output  1  sticky abort flag.

Function
REQ-017 FSM states: IDLE, REQ, DONE; encoding implementer's choice.
REQ-018 IDLE: stall_o = MemRead_i | MemWrite_i (combinational, same cycle); mem_enable_o=0.
REQ-019 IDLE with request: next edge -> REQ; latch addr_i, wdata_i, write flag = MemWrite_i; clear wait counter.
REQ-020 MemRead_i and MemWrite_i both 1: treated as store.
REQ-021 REQ: mem_enable_o=1, stall_o=1; mem_addr_o/mem_data_o/mem_write_o held constant.
REQ-022 REQ and mem_ack_i=1: next edge -> DONE; load: rdata_o <= mem_rdata_i; store: rdata_o unchanged.
REQ-023 REQ and mem_ack_i=0: 8-bit wait counter increments per cycle.
REQ-024 Counter reaches TIMEOUT-1 with mem_ack_i=0: next edge -> DONE; timeout_o <= 1; rdata_o <= 0 for loads.
REQ-025 mem_ack_i=1 in the same cycle the timeout triggers: ack wins, no timeout.
REQ-026 DONE: stall_o=0, mem_enable_o=0 for exactly one cycle; pipeline advances past the finished op.
REQ-027 DONE: request inputs ignored; next edge -> IDLE unconditionally (no re-issue of the retiring op).
REQ-028 mem_ack_i in IDLE or DONE: ignored; no state or output change.
REQ-029 Op latency: IDLE request cycle + N REQ cycles + 1 DONE cycle; ack in first REQ cycle gives stall high for 2 cycles.
REQ-030 timeout_o stays 1 until reset; it does not block later requests.

Reset
REQ-031 rst_i=0: immediately (no clock) state=IDLE; mem_enable_o, mem_write_o, timeout_o = 0; mem_addr_o, mem_data_o, rdata_o = 0; wait counter = 0.
REQ-032 stall_o under reset is driven only by the IDLE rule (REQ-018).
REQ-033 Reset asserted in REQ: request dropped; mem_enable_o falls asynchronously; no retry after release.
REQ-034 First state transition possible on first rising edge after rst_i deasserts.

Verification
REQ-035 Load, addr=0x0000_0040, ack 3 cycles after REQ entry, mem_rdata_i=0xDEAD_BEEF -> stall_o high 5 cycles, rdata_o=0xDEAD_BEEF in DONE, mem_write_o=0.
REQ-036 Store, addr=0x10, wdata=0x1234_5678, ack in first REQ cycle -> mem_write_o=1, mem_data_o=0x1234_5678, stall_o high exactly 2 cycles.
REQ-037 TIMEOUT=16, load, no ack -> DONE after 16 REQ cycles, timeout_o=1, rdata_o=0; following load acked normally, timeout_o stays 1.
REQ-038 Ack on the final timeout cycle with mem_rdata_i=0xA5A5_A5A5 -> rdata_o=0xA5A5_A5A5, timeout_o stays 0.
REQ-039 MemRead_i held high through DONE -> single memory transaction only, IDLE reached, new transaction only if request is still present in IDLE.
REQ-040 rst_i pulsed low mid-REQ -> outputs reset without a clock edge, no mem_enable_o after release until a new request.
